// File: rtl/text_ram_arbiter_pkg.sv
// Shared constants and types for the text character RAM arbiter slice.
// Screen geometry, data widths, the return-tag and clear-state encodings.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 40;
  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] FILL_CHAR = 8'h20;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {RT_NONE, RT_VID, RT_HOST} rtag_t;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < DEPTH_A;
  endfunction

endpackage

// File: rtl/text_ram_arbiter_clear_seq.sv
// Full-screen clear sequencer: walks the pointer 0..DEPTH-1, one write per
// unstalled cycle. Only instantiated when TEXT_CLEAR_EN is defined.
module text_clear_seq
  import text_pkg::*;
(
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output clr_state_t        state_o
);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_IDLE: begin
        if (start_i) begin
          state_d = CLR_RUN;
          ptr_d   = '0;
        end
      end
      CLR_RUN: begin
        // A stalled cycle (video owns the RAM) leaves the pointer in place.
        if (!stall_i) begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_A) begin
            state_d = CLR_IDLE;
            ptr_d   = '0;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == CLR_RUN);
    wr_en_o   = (state_q == CLR_RUN) & ~stall_i;
    wr_addr_o = ptr_q;
    state_o   = state_q;
  end

endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM owner: video > clear > host arbitration plus read-return
// routing. The optional clear sequencer is built when TEXT_CLEAR_EN is defined.
module text_ram_arbiter
  import text_pkg::*;
(
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              clr_wr_en;
  logic [ADDR_W-1:0] clr_addr;

`ifdef TEXT_CLEAR_EN
  clr_state_t clr_state;

  text_clear_seq u_clr (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .start_i   (clr_start),
    .stall_i   (vid_req),
    .busy_o    (clr_busy),
    .wr_en_o   (clr_wr_en),
    .wr_addr_o (clr_addr),
    .state_o   (clr_state)
  );

  always_comb begin
    assert (!clr_busy || clr_state == CLR_RUN);
  end
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clr_busy         = 1'b0;
  assign clr_wr_en        = 1'b0;
  assign clr_addr         = '0;
`endif

  // Host handshake: a transfer happens on a cycle with host_valid & host_ready;
  // the host holds valid, we, addr and wdata stable until that cycle.
  logic host_acc;
  assign host_ready = host_valid & ~vid_req & ~clr_busy;
  assign host_acc   = host_valid & host_ready;

  rtag_t tag_d, tag_q;
  logic  zero_d, zero_q;
  logic  vid_in, host_in;

  assign vid_in  = in_range(vid_addr);
  assign host_in = in_range(host_addr);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    tag_d     = RT_NONE;
    zero_d    = 1'b0;
    if (vid_req) begin
      ram_en   = vid_in;
      ram_addr = vid_addr;
      tag_d    = RT_VID;
      zero_d   = ~vid_in;
    end else if (clr_wr_en) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = FILL_CHAR;
    end else if (host_acc) begin
      // Out-of-range host accesses are accepted but never reach the RAM.
      ram_en    = host_in;
      ram_we    = host_in & host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      if (!host_we) begin
        tag_d  = RT_HOST;
        zero_d = ~host_in;
      end
    end
  end

  logic [DATA_W-1:0] vid_hold_q, host_hold_q;
  logic [DATA_W-1:0] ret_data;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      tag_q       <= RT_NONE;
      zero_q      <= 1'b0;
      vid_hold_q  <= '0;
      host_hold_q <= '0;
    end else begin
      tag_q       <= tag_d;
      zero_q      <= zero_d;
      vid_hold_q  <= vid_data;
      host_hold_q <= host_rdata;
    end
  end

  assign ret_data    = zero_q ? '0 : ram_rdata;
  assign vid_valid   = (tag_q == RT_VID);
  assign host_rvalid = (tag_q == RT_HOST);
  assign vid_data    = vid_valid ? ret_data : vid_hold_q;
  assign host_rdata  = host_rvalid ? ret_data : host_hold_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: directed vectors, a per-cycle reference model of
// the arbitration rules, and a behavioural single-port RAM on the ram_* side.
module tb_text_ram_arbiter;

  localparam int DEPTH = 3200;
  localparam logic [7:0] FILL = 8'h20;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [11:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        clr_start;
  logic        clr_busy;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int errors = 0;

  text_ram_arbiter dut (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // clock / reset
  always #5 vga_clk = ~vga_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // single-port RAM with 1-cycle synchronous read
  logic [7:0] ram_mem [0:4095];
  always @(posedge vga_clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model and per-cycle scoreboard
  logic [7:0]  ref_mem [0:DEPTH-1];
  int          clr_hits [0:DEPTH-1];
  logic [7:0]  exp_q [$];
  logic        vid_pend, host_pend;
  logic [7:0]  vid_exp, host_exp, last_vid, last_host;
  logic        m_busy, busy_nx;
  int          m_ptr;
  logic        e_en, e_we, e_rdy;
  logic [11:0] e_addr;
  logic [7:0]  e_wd;

  always @(negedge vga_clk) begin
    if (rst) begin
      m_busy    = 1'b0;
      m_ptr     = 0;
      vid_pend  = 1'b0;
      host_pend = 1'b0;
      last_vid  = 8'h00;
      last_host = 8'h00;
      exp_q.delete();
    end else begin
      check("vid_valid", vid_valid, vid_pend);
      if (vid_pend) last_vid = vid_exp;
      check("vid_data", vid_data, last_vid);
      check("host_rvalid", host_rvalid, host_pend);
      if (host_pend) last_host = exp_q.pop_front();
      check("host_rdata", host_rdata, last_host);
      vid_pend  = 1'b0;
      host_pend = 1'b0;

      check("clr_busy", clr_busy, m_busy);
      if (ram_en && ram_we && clr_busy && ram_addr < DEPTH) clr_hits[ram_addr]++;

      e_en = 0; e_we = 0; e_rdy = 0; e_addr = '0; e_wd = '0;
      busy_nx = m_busy;
      if (vid_req) begin
        vid_pend = 1'b1;
        if (vid_addr < DEPTH) begin
          e_en    = 1;
          e_addr  = vid_addr;
          vid_exp = ref_mem[vid_addr];
        end else begin
          vid_exp = 8'h00;
        end
      end else if (m_busy) begin
        e_en   = 1;
        e_we   = 1;
        e_addr = 12'(m_ptr);
        e_wd   = FILL;
        ref_mem[m_ptr] = FILL;
        m_ptr++;
        if (m_ptr == DEPTH) busy_nx = 1'b0;
      end else if (host_valid) begin
        e_rdy = 1;
        if (host_addr < DEPTH) begin
          e_en   = 1;
          e_we   = host_we;
          e_addr = host_addr;
          e_wd   = host_wdata;
        end
        if (host_we) begin
          if (host_addr < DEPTH) ref_mem[host_addr] = host_wdata;
        end else begin
          host_pend = 1'b1;
          exp_q.push_back((host_addr < DEPTH) ? ref_mem[host_addr] : 8'h00);
        end
      end
`ifdef TEXT_CLEAR_EN
      if (!m_busy && clr_start) begin
        busy_nx = 1'b1;
        m_ptr   = 0;
      end
`endif
      check("host_ready", host_ready, e_rdy);
      check("ram_en", ram_en, e_en);
      check("ram_we", ram_we, e_we);
      if (e_en) check("ram_addr", ram_addr, e_addr);
      if (e_we) check("ram_wdata", ram_wdata, e_wd);
      m_busy = busy_nx;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                         output int waited);
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wd;
    waited     = 0;
    forever begin
      @(negedge vga_clk);
      if (host_ready) break;
      waited++;
      if (waited > 6000) begin
        check("host_accept_timeout", 32'd1, 32'd0);
        break;
      end
      step();
    end
    step();
    host_valid = 1'b0;
  endtask

  task automatic clear_hits();
    for (int i = 0; i < DEPTH; i++) clr_hits[i] = 0;
  endtask

  int waited, busy_cnt, nvid, n, writes, bad, total;

  initial begin
    rst = 1'b1;
    vid_req = 0; vid_addr = '0;
    host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    clr_start = 0;
    clear_hits();

    // reset state
    step(); step();
    @(negedge vga_clk);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    step();
    rst = 1'b0;
    step();

    // 1: host write 0x41 @5, then read back
    host_op(1'b1, 12'd5, 8'h41, waited);
    check("t1_write_wait", waited, 0);
    host_op(1'b0, 12'd5, 8'h00, waited);
    check("t1_read_wait", waited, 0);
    @(negedge vga_clk);
    check("t1_rvalid", host_rvalid, 1);
    check("t1_rdata", host_rdata, 8'h41);
    step();

    // 2: video and host collide; video wins, host follows
    host_op(1'b1, 12'd7, 8'h37, waited);
    vid_req = 1; vid_addr = 12'd5;
    host_valid = 1; host_we = 0; host_addr = 12'd7;
    @(negedge vga_clk);
    check("t2_ram_addr", ram_addr, 12'd5);
    check("t2_ram_en", ram_en, 1);
    check("t2_host_ready", host_ready, 0);
    step();
    vid_req = 0;
    @(negedge vga_clk);
    check("t2_vid_valid", vid_valid, 1);
    check("t2_vid_data", vid_data, 8'h41);
    check("t2_host_ready_after", host_ready, 1);
    step();
    host_valid = 0;
    @(negedge vga_clk);
    check("t2_host_rvalid", host_rvalid, 1);
    check("t2_host_rdata", host_rdata, 8'h37);
    check("t2_vid_valid_drop", vid_valid, 0);
    step();

    // 3: out-of-range host and video addresses
    host_valid = 1; host_we = 1; host_addr = 12'd3200; host_wdata = 8'h55;
    @(negedge vga_clk);
    check("t3_wr_ready", host_ready, 1);
    check("t3_wr_ram_en", ram_en, 0);
    step();
    host_we = 0;
    @(negedge vga_clk);
    check("t3_rd_ready", host_ready, 1);
    check("t3_rd_ram_en", ram_en, 0);
    step();
    host_valid = 0;
    @(negedge vga_clk);
    check("t3_rvalid", host_rvalid, 1);
    check("t3_rdata", host_rdata, 8'h00);
    step();
    vid_req = 1; vid_addr = 12'd4000;
    @(negedge vga_clk);
    check("t3_vid_ram_en", ram_en, 0);
    step();
    vid_req = 0;
    @(negedge vga_clk);
    check("t3_vid_valid", vid_valid, 1);
    check("t3_vid_data", vid_data, 8'h00);
    step();

    // mixed writes then video reads
    for (int i = 0; i < 16; i++) host_op(1'b1, 12'(i * 200 + 3), 8'(i * 7 + 1), waited);
    for (int i = 0; i < 16; i++) begin
      vid_req = 1; vid_addr = 12'(i * 200 + 3);
      step();
    end
    vid_req = 1; vid_addr = 12'd203;
    step();
    vid_req = 0;
    @(negedge vga_clk);
    check("mix_vid_203", vid_data, 8'h08);
    step();

`ifdef TEXT_CLEAR_EN
    // 4: clear with no video, host read pending behind it
    clr_start = 1;
    @(negedge vga_clk);
    check("t4_busy_start_cycle", clr_busy, 0);
    step();
    clr_start = 0;
    host_valid = 1; host_we = 0; host_addr = 12'd5;
    @(negedge vga_clk);
    check("t4_busy_first", clr_busy, 1);
    check("t4_host_stalled", host_ready, 0);
    busy_cnt = 1;
    n = 0;
    while (n < 5000) begin
      step();
      @(negedge vga_clk);
      if (!clr_busy) break;
      busy_cnt++;
      n++;
    end
    check("t4_busy_cycles", busy_cnt, 3200);
    check("t4_host_after_clear", host_ready, 1);
    step();
    host_valid = 0;
    @(negedge vga_clk);
    check("t4_host_rdata", host_rdata, 8'h20);
    bad = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      step();
      if (i < DEPTH) begin
        host_valid = 1; host_we = 0; host_addr = 12'(i);
      end else begin
        host_valid = 0;
      end
      @(negedge vga_clk);
      if (i > 0 && (host_rvalid !== 1'b1 || host_rdata !== 8'h20)) bad++;
    end
    check("t4_readback_bad", bad, 0);
    step();

    // 5: clear interleaved with video every 4th cycle
    clear_hits();
    clr_start = 1;
    step();
    clr_start = 0;
    busy_cnt = 0; nvid = 0; n = 0;
    while (n < 6000) begin
      vid_req  = (n % 4 == 3);
      vid_addr = 12'((n * 13) % DEPTH);
      @(negedge vga_clk);
      if (!clr_busy) break;
      busy_cnt++;
      if (vid_req) nvid++;
      n++;
      step();
    end
    vid_req = 0;
    check("t5_busy_vs_vid", busy_cnt, 3200 + nvid);
    check("t5_nvid", nvid, 1066);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (clr_hits[i] != 1) bad++;
    check("t5_hits_not_once", bad, 0);
    step();

    // 6: reset mid-clear at ptr = 1000, then restart
    clear_hits();
    clr_start = 1;
    step();
    clr_start = 0;
    writes = 0; n = 0;
    while (writes < 1000 && n < 5000) begin
      @(negedge vga_clk);
      if (ram_en && ram_we) writes++;
      n++;
      if (writes < 1000) step();
    end
    check("t6_writes_before_rst", writes, 1000);
    step();
    rst = 1;
    @(negedge vga_clk);
    check("t6_rst_busy", clr_busy, 0);
    check("t6_rst_ram_en", ram_en, 0);
    check("t6_rst_vid_valid", vid_valid, 0);
    check("t6_rst_host_rvalid", host_rvalid, 0);
    step(); step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge vga_clk);
      check("t6_idle_ram_en", ram_en, 0);
      check("t6_idle_busy", clr_busy, 0);
      step();
    end
    total = 0;
    for (int i = 0; i < DEPTH; i++) total += clr_hits[i];
    check("t6_hits_total", total, 1000);
    check("t6_hit_999", clr_hits[999], 1);
    check("t6_hit_1000", clr_hits[1000], 0);
    clr_start = 1;
    step();
    clr_start = 0;
    @(negedge vga_clk);
    check("t6_restart_busy", clr_busy, 1);
    check("t6_restart_we", ram_we, 1);
    check("t6_restart_addr", ram_addr, 12'd0);
    n = 0;
    while (clr_busy && n < 5000) begin
      step();
      @(negedge vga_clk);
      n++;
    end
    check("t6_restart_done", clr_busy, 0);
    step();
`else
    // clear disabled: clr_start is ignored and the host is never stalled
    clr_start = 1;
    host_valid = 1; host_we = 0; host_addr = 12'd5;
    @(negedge vga_clk);
    check("noclr_ready", host_ready, 1);
    check("noclr_busy", clr_busy, 0);
    step();
    clr_start = 0;
    host_valid = 0;
    @(negedge vga_clk);
    check("noclr_busy_after", clr_busy, 0);
    check("noclr_rvalid", host_rvalid, 1);
    check("noclr_rdata", host_rdata, 8'h41);
    step();
`endif

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
